// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: steps one shared BCD decoder across
// N_DIGITS positions with per-slot dead time, frame-coherent loads, blanking and blinking.
module display_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int DIV          = 50000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 60
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic [N_DIGITS-1:0]     blink_mask,
    output logic [3:0]              bcd_out,
    output logic [N_DIGITS-1:0]     digit_sel,
    output logic                    frame_done,
    output logic                    load_ack
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic {S_GUARD, S_ON} state_t;

    localparam state_t STATE_RST = (GUARD > 0) ? S_GUARD : S_ON;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic [FW-1:0]           fcnt, fcnt_n;
    logic                    blink_phase, phase_n;
    logic [4*N_DIGITS-1:0]   stg, stg_n;
    logic [4*N_DIGITS-1:0]   act, act_n;
    logic                    pending, pending_n;
    logic                    ack_n;
    logic                    slot_end, wrap;
    logic [3:0]              bcd_n;
    logic [N_DIGITS-1:0]     sel_n;

    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    // State register plus scan counters and the staging/active value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= STATE_RST;
            cnt         <= '0;
            idx         <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
            stg         <= '0;
            act         <= '0;
            pending     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            fcnt        <= fcnt_n;
            blink_phase <= phase_n;
            stg         <= stg_n;
            act         <= act_n;
            pending     <= pending_n;
        end
    end

    // Slot/digit/frame counting; act only ever changes on the wrap so a frame is never mixed.
    always_comb begin
        cnt_n     = slot_end ? '0 : cnt + 1'b1;
        idx_n     = idx;
        fcnt_n    = fcnt;
        phase_n   = blink_phase;
        stg_n     = stg;
        act_n     = act;
        pending_n = pending;
        ack_n     = 1'b0;

        if (slot_end)
            idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;

        if (wrap) begin
            if (fcnt == FCNT_LAST) begin
                fcnt_n  = '0;
                phase_n = ~blink_phase;
            end else begin
                fcnt_n = fcnt + 1'b1;
            end
        end

        if (wrap) begin
            if (load) begin
                act_n = digits_in;
                stg_n = digits_in;
                ack_n = 1'b1;
            end else if (pending) begin
                act_n = stg;
                ack_n = 1'b1;
            end
            pending_n = 1'b0;
        end else if (load) begin
            stg_n     = digits_in;
            pending_n = 1'b1;
        end
    end

    // Next-state: dead time at the start of each slot, on for the remainder.
    always_comb begin
        state_n = state;
        case (state)
            S_GUARD: state_n = (int'(cnt_n) >= GUARD) ? S_ON : S_GUARD;
            S_ON:    state_n = (slot_end && (GUARD > 0)) ? S_GUARD : S_ON;
            default: state_n = STATE_RST;
        endcase
    end

    // Outputs are computed from next-cycle values so the registered copy matches the current slot.
    always_comb begin
        bcd_n = act_n[{idx_n, 2'b00} +: 4];
        sel_n = '0;
        if ((state_n == S_ON) && !blank_mask[idx_n] && !(blink_mask[idx_n] && phase_n))
            sel_n[idx_n] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out    <= 4'h0;
            digit_sel  <= '0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            bcd_out    <= bcd_n;
            digit_sel  <= sel_n;
            frame_done <= wrap;
            load_ack   <= ack_n;
        end
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller that shares one 4-bit-to-7-segment decoder among N_DIGITS common-anode/cathode digit positions of the parking-spot display. It holds a frame-coherent copy of the digit values and steps through the digits one at a time. Each digit gets a guard (dead-time) interval, then an on interval. It presents that digit's BCD code to the decoder and asserts its one-hot digit enable. It also provides per-digit blanking and blinking, for example to flag a full lot.

## Interface

- N_DIGITS, 4: number of multiplexed digits (≥2).
- DIV, 50000: clock cycles per digit slot (≥2).
- GUARD, 500: cycles at slot start with all digits off (0 ≤ GUARD < DIV).
- BLINK_FRAMES, 60: complete frames per blink half-period (≥1).

- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous active-low reset.
- digits_in  in  4*N_DIGITS  digit values; digit k = bits [4k+3:4k], 4'h0–4'hF.
- load  in  1  single-cycle strobe that captures digits_in.
- blank_mask  in  N_DIGITS  bit k=1 keeps digit k permanently off.
- blink_mask  in  N_DIGITS  bit k=1 turns digit k off during the blink-off phase.
- bcd_out  out  4  code to decoder inputs {A,B,C,D}; A = bit 3.
- digit_sel  out  N_DIGITS  one-hot active-high digit enable; all zero while off.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to 0.
- load_ack  out  1  one-cycle pulse when newly loaded values become active.

## Operation

- Registers:
  - slot counter cnt, 0..DIV-1.
  - digit index idx, 0..N_DIGITS-1.
  - staging register stg and pending flag.
  - active register act.
  - frame counter fcnt, 0..BLINK_FRAMES-1.
  - blink_phase.
- State per slot:
  - GUARD when cnt < GUARD.
  - ON when cnt ≥ GUARD.
  - With GUARD=0 there is no GUARD state.
- Transitions:
  - GUARD→ON when cnt reaches GUARD.
  - ON→GUARD of the next digit at cnt==DIV-1. At that point cnt←0 and idx←idx+1, wrapping N_DIGITS-1→0.
- Wrap event: the cycle in which cnt==DIV-1 and idx==N_DIGITS-1.
  - frame_done=1 on the following cycle.
  - fcnt increments. When fcnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Load handshake:
  - A load outside the wrap event sets stg←digits_in and pending←1. The last load before a wrap wins.
  - At the wrap event with pending=1: act←stg, pending←0, load_ack=1 on the next cycle.
  - A load in the wrap-event cycle itself writes digits_in directly into act and clears pending; it overrides stg. load_ack pulses on the next cycle.
  - act changes only at frame boundaries, so no frame shows mixed values.
- Output rule, registered, for the current (idx, cnt):
  - bcd_out = act[idx].
  - digit_sel[idx]=1 only when all three hold: state is ON, blank_mask[idx]=0, and NOT (blink_mask[idx]=1 AND blink_phase=1).
  - All other digit_sel bits are 0. bcd_out updates in GUARD even when the digit is off.
  - blank_mask and blink_mask are sampled live every cycle and are not frame-aligned.
- Reset (asynchronous, while rst_n=0):
  - cnt=0, idx=0, fcnt=0, blink_phase=0.
  - stg=0, act=0, pending=0.
  - Outputs: bcd_out=4'h0, digit_sel=0, frame_done=0, load_ack=0.
  - A reset in mid-frame discards pending loads. After release, scanning restarts at digit 0, cnt=0.

## Timing

- Slot length is DIV cycles. Frame length is N_DIGITS·DIV cycles. Blink half-period is BLINK_FRAMES frames.
- Outputs are registered. In the first cycle after reset release, outputs reflect idx=0, cnt=0: digit_sel=0 if GUARD>0.
- digit_sel is exactly 0 for the GUARD cycles at the start of every slot. It is never multi-hot.
- Load latency: from a load pulse to load_ack is 1 to N_DIGITS·DIV cycles, depending on position in the frame.
- bcd_out shows the new values at digit 0 in the cycle load_ack is high.
- frame_done and load_ack coincide when a transfer happens.

## Test plan

All scenarios use N_DIGITS=4, DIV=8, GUARD=2, BLINK_FRAMES=2.

1. Reset then free-run.
   - Stimulus: release reset and let the scan run.
   - Required: digit_sel=0000 for 2 cycles, then 0001 for 6 cycles, then 0000 for 2 cycles, then 0010, and so on.
   - Required: frame_done pulses every 32 cycles, first at cycle 32 after release.
2. Load mid-frame.
   - Stimulus: load digits_in=16'h4321 at cycle 10.
   - Required: act, and so bcd_out, unchanged until the wrap.
   - Required: load_ack and frame_done together at cycle 32; bcd_out=1,2,3,4 on digits 0..3 of the next frame.
3. Load collisions.
   - Stimulus: two loads, 16'h1111 then 16'h9999, in the same frame.
   - Required: only 9999 is displayed and a single load_ack occurs.
   - Stimulus: a load coinciding with the wrap-event cycle.
   - Required: that value is applied immediately and load_ack pulses on the next cycle.
4. Blanking and blinking.
   - Stimulus: blank_mask=0100.
   - Required: digit_sel[2] never asserts.
   - Stimulus: blink_mask=0001.
   - Required: digit_sel[0] asserts in frames 0–1, is suppressed in frames 2–3, and asserts again in frames 4–5.
5. Asynchronous reset mid-slot.
   - Stimulus: assert rst_n=0 at cnt=5, idx=2, with a load pending.
   - Required: outputs go to reset values immediately without waiting for clk.
   - Required: after release, digit 0 is scanned and bcd_out=0; the pending load is lost and no load_ack occurs.
6. Invariant check.
   - Required over 1000 random cycles with random loads and masks: digit_sel is always one-hot or zero.
   - Required: digit_sel is zero whenever cnt<2.
